// File: rtl/pam4_tx.sv
// PAM4 transmit source: user symbols or PRBS7 training bursts, Gray-mapped to
// signed levels and passed through a one-post-cursor ISI channel model.
module pam4_tx #(
  parameter int         SIGNAL_RESOLUTION = 8,
  parameter int         SYMBOL_SEPERATION = 56,
  parameter int         H1_SHIFT          = 1,
  parameter int         SYMBOL_PERIOD     = 2,
  parameter int         TRAIN_LENGTH      = 127,
  parameter logic [6:0] PRBS_SEED         = 7'h7F
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [1:0]                          data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic                                train_start,
  output logic                                training,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] train_data,
  output logic                                train_data_valid
);

  localparam int R  = SIGNAL_RESOLUTION;
  localparam int WW = SIGNAL_RESOLUTION + 2;
  localparam int HW = (SYMBOL_PERIOD > 1) ? $clog2(SYMBOL_PERIOD) : 1;
  localparam int CW = (TRAIN_LENGTH > 1) ? $clog2(TRAIN_LENGTH) : 1;

  localparam logic signed [R-1:0]  LVL_1     = R'(SYMBOL_SEPERATION / 2);
  localparam logic signed [R-1:0]  LVL_3     = R'((3 * SYMBOL_SEPERATION) / 2);
  localparam logic signed [WW-1:0] SAT_MAX   = WW'((2 ** (R - 1)) - 1);
  localparam logic signed [WW-1:0] SAT_MIN   = WW'(-(2 ** (R - 1)));
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(SYMBOL_PERIOD - 1);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(TRAIN_LENGTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRAIN = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [HW-1:0]       holdoff_r;
  logic [CW-1:0]       sym_cnt_r;
  logic [CW-1:0]       sym_cnt_nxt_s;
  logic [6:0]          lfsr_r;
  logic [6:0]          lfsr_nxt_s;
  logic signed [R-1:0] prev_level_r;
  logic                hold_zero_s;
  logic                emit_s;
  logic [1:0]          sym_s;
  logic signed [R-1:0] level_s;
  logic signed [R-1:0] sample_s;

  function automatic logic signed [R-1:0] gray_level(input logic [1:0] sym);
    case (sym)
      2'b00:   gray_level = -LVL_3;
      2'b01:   gray_level = -LVL_1;
      2'b11:   gray_level = LVL_1;
      2'b10:   gray_level = LVL_3;
      default: gray_level = '0;
    endcase
  endfunction

  // Widened sum keeps the post-cursor addition overflow-free before clamping.
  function automatic logic signed [R-1:0] channel_out(input logic signed [R-1:0] level,
                                                      input logic signed [R-1:0] prev);
    logic signed [WW-1:0] sum;
    sum = $signed({{2{level[R-1]}}, level}) + ($signed({{2{prev[R-1]}}, prev}) >>> H1_SHIFT);
    if (sum > SAT_MAX) begin
      channel_out = SAT_MAX[R-1:0];
    end else if (sum < SAT_MIN) begin
      channel_out = SAT_MIN[R-1:0];
    end else begin
      channel_out = sum[R-1:0];
    end
  endfunction

  // Two PRBS7 steps per symbol since each symbol consumes two bits.
  function automatic logic [6:0] prbs_step2(input logic [6:0] s);
    logic [6:0] t;
    t          = {s[5:0], s[6] ^ s[5]};
    prbs_step2 = {t[5:0], t[6] ^ t[5]};
  endfunction

  assign hold_zero_s   = (holdoff_r == '0);
  assign data_in_ready = rstn && (state_r == ST_IDLE) && hold_zero_s && !train_start;
  assign level_s       = gray_level(sym_s);
  assign sample_s      = channel_out(level_s, prev_level_r);

  // Next-state, emission decision and symbol source selection.
  always_comb begin
    state_nxt_s   = state_r;
    sym_cnt_nxt_s = sym_cnt_r;
    lfsr_nxt_s    = lfsr_r;
    emit_s        = 1'b0;
    sym_s         = data_in;
    case (state_r)
      ST_IDLE: begin
        if (train_start && hold_zero_s) begin
          state_nxt_s   = ST_TRAIN;
          lfsr_nxt_s    = PRBS_SEED;
          sym_cnt_nxt_s = '0;
        end else if (data_in_valid && data_in_ready) begin
          emit_s = 1'b1;
          sym_s  = data_in;
        end else begin
          emit_s = 1'b0;
        end
      end
      ST_TRAIN: begin
        if (hold_zero_s) begin
          emit_s     = 1'b1;
          sym_s      = {lfsr_r[6], lfsr_r[5]};
          lfsr_nxt_s = prbs_step2(lfsr_r);
          if (sym_cnt_r == CNT_LAST) begin
            state_nxt_s   = ST_IDLE;
            sym_cnt_nxt_s = '0;
          end else begin
            sym_cnt_nxt_s = sym_cnt_r + CW'(1);
          end
        end else begin
          emit_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        sym_cnt_nxt_s = '0;
        lfsr_nxt_s    = PRBS_SEED;
      end
    endcase
  end

  // Control state: FSM, burst counter, LFSR and symbol pacing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      sym_cnt_r <= '0;
      lfsr_r    <= PRBS_SEED;
      holdoff_r <= '0;
      training  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      sym_cnt_r <= sym_cnt_nxt_s;
      lfsr_r    <= lfsr_nxt_s;
      training  <= (state_nxt_s == ST_TRAIN);
      if (emit_s) begin
        holdoff_r <= HOLD_LOAD;
      end else if (!hold_zero_s) begin
        holdoff_r <= holdoff_r - HW'(1);
      end
    end
  end

  // Output samples; values hold between emissions, valids pulse once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_level_r     <= '0;
      signal_out       <= '0;
      signal_out_valid <= 1'b0;
      train_data       <= '0;
      train_data_valid <= 1'b0;
    end else if (emit_s) begin
      prev_level_r     <= level_s;
      signal_out       <= sample_s;
      signal_out_valid <= 1'b1;
      if (state_r == ST_TRAIN) begin
        train_data       <= level_s;
        train_data_valid <= 1'b1;
      end else begin
        train_data_valid <= 1'b0;
      end
    end else begin
      signal_out_valid <= 1'b0;
      train_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pam4_tx.sv
// Directed bench for pam4_tx: a cycle-level behavioural model checked every
// cycle, plus hand-computed literals; a second instance uses H1_SHIFT=0.
module tb_pam4_tx;

  localparam int R  = 8;
  localparam int S  = 56;
  localparam int P  = 2;
  localparam int TL = 127;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic data_in_valid = 1'b0;
  logic train_start = 1'b0;

  logic data_in_ready, training, signal_out_valid, train_data_valid;
  logic signed [R-1:0] signal_out, train_data;
  logic s2_ready, s2_training, s2_valid, s2_tvalid;
  logic signed [R-1:0] s2_out, s2_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  int prbs[TL];
  int m_train, m_idx, m_hold, m_prev;
  int e_so, e_sv, e_td, e_tv, e_tr;

  always #5 clk = ~clk;

  pam4_tx dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .train_start(train_start), .training(training),
    .signal_out(signal_out), .signal_out_valid(signal_out_valid),
    .train_data(train_data), .train_data_valid(train_data_valid)
  );

  pam4_tx #(.H1_SHIFT(0)) dut_h0 (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(s2_ready), .train_start(train_start), .training(s2_training),
    .signal_out(s2_out), .signal_out_valid(s2_valid),
    .train_data(s2_tdata), .train_data_valid(s2_tvalid)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int sym);
    case (sym)
      0:       return -(3 * S) / 2;
      1:       return -S / 2;
      3:       return S / 2;
      default: return (3 * S) / 2;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > (2 ** (R - 1)) - 1) return (2 ** (R - 1)) - 1;
    if (v < -(2 ** (R - 1))) return -(2 ** (R - 1));
    return v;
  endfunction

  // Behavioural model: training burst is a precomputed symbol list.
  initial begin
    int l, nb, sym, lvl;
    l = 7'h7F;
    for (int i = 0; i < TL; i++) begin
      prbs[i] = ((l >> 6) & 1) * 2 + ((l >> 5) & 1);
      for (int k = 0; k < 2; k++) begin
        nb = ((l >> 6) ^ (l >> 5)) & 1;
        l  = ((l << 1) & 127) | nb;
      end
    end
    m_train = 0; m_idx = 0; m_hold = 0; m_prev = 0;
    e_so = 0; e_sv = 0; e_td = 0; e_tv = 0; e_tr = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_train = 0; m_idx = 0; m_hold = 0; m_prev = 0;
        e_so = 0; e_sv = 0; e_td = 0; e_tv = 0; e_tr = 0;
      end else if (m_train == 0 && m_hold == 0 && train_start) begin
        m_train = 1; m_idx = 0; e_sv = 0; e_tv = 0;
      end else if ((m_train == 1 && m_hold == 0) ||
                   (m_train == 0 && m_hold == 0 && data_in_valid)) begin
        sym    = (m_train == 1) ? prbs[m_idx] : int'(data_in);
        lvl    = lvl_of(sym);
        e_so   = clamp(lvl + (m_prev >>> H1));
        e_sv   = 1;
        m_prev = lvl;
        m_hold = P - 1;
        if (m_train == 1) begin
          e_td = lvl; e_tv = 1; m_idx++;
          if (m_idx == TL) m_train = 0;
        end else begin
          e_tv = 0;
        end
      end else begin
        e_sv = 0; e_tv = 0;
        if (m_hold > 0) m_hold--;
      end
      e_tr = m_train;
    end
  end

  // Compare process: every output, every cycle.
  initial forever begin
    @(negedge clk);
    chk("signal_out", signal_out, e_so);
    chk("signal_out_valid", signal_out_valid, e_sv);
    chk("train_data", train_data, e_td);
    chk("train_data_valid", train_data_valid, e_tv);
    chk("training", training, e_tr);
    chk("data_in_ready", data_in_ready,
        (rstn && m_train == 0 && m_hold == 0 && !train_start) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("async_rst_out", signal_out, 0);
    chk("async_rst_valid", signal_out_valid, 0);
    chk("async_rst_train", training, 0);
    chk("async_rst_tdata", train_data, 0);
    rstn = 1'b1;
  endtask

  task automatic run_burst(input bit check_first, input bit poke, input int abort_at,
                           output int pulses);
    pulses = 0;
    for (int c = 0; c < 400; c++) begin
      if (poke) begin
        data_in       = 2'b10;
        data_in_valid = 1'b1;
        train_start   = (pulses >= 10 && pulses < 14);
      end
      tick();
      if (signal_out_valid) begin
        pulses++;
        chk("burst_tdvalid", train_data_valid, 1);
        if (check_first && pulses == 1) begin
          chk("burst_first_out", signal_out, 28);
          chk("burst_first_td", train_data, 28);
        end
        if (check_first && pulses == 2) begin
          chk("burst_second_out", signal_out, 42);
          chk("burst_second_td", train_data, 28);
        end
      end
      if (abort_at != 0 && pulses == abort_at) begin
        train_start = 1'b0; data_in_valid = 1'b0;
        do_reset();
        return;
      end
      if (!training) break;
    end
    train_start = 1'b0; data_in_valid = 1'b0;
    if (training) begin
      n_tests++; n_fail++;
      $display("FAIL burst_timeout: training still high after 400 cycles");
    end
  endtask

  initial begin
    int p;
    // Reset state
    repeat (2) tick();
    chk("rst_training", training, 0);
    chk("rst_ready_low", data_in_ready, 0);
    rstn = 1'b1;
    tick();
    chk("idle_ready", data_in_ready, 1);
    chk("idle_out", signal_out, 0);
    chk("idle_valid", signal_out_valid, 0);

    // Paced user symbols
    data_in = 2'b10; data_in_valid = 1'b1;
    #1;
    chk("t2_ready0", data_in_ready, 1);
    tick();
    chk("t2_out0", signal_out, 84);
    chk("t2_valid0", signal_out_valid, 1);
    chk("t2_ready1", data_in_ready, 0);
    data_in = 2'b00;
    tick();
    chk("t2_valid1", signal_out_valid, 0);
    chk("t2_hold", signal_out, 84);
    chk("t2_ready2", data_in_ready, 1);
    tick();
    chk("t2_out1", signal_out, -42);
    chk("t2_valid2", signal_out_valid, 1);
    data_in_valid = 1'b0;
    tick();
    chk("t2_valid3", signal_out_valid, 0);
    do_reset();

    // Saturation on the H1_SHIFT=0 instance
    data_in = 2'b10; data_in_valid = 1'b1;
    tick();
    chk("t3_h0_out0", s2_out, 84);
    tick(); tick();
    chk("t3_h0_sat_hi", s2_out, 127);
    chk("t3_h0_valid", s2_valid, 1);
    chk("t3_h1_out", signal_out, 126);
    data_in_valid = 1'b0;
    do_reset();
    data_in = 2'b00; data_in_valid = 1'b1;
    tick();
    chk("t3_h0_neg0", s2_out, -84);
    tick(); tick();
    chk("t3_h0_sat_lo", s2_out, -128);
    chk("t3_h1_neg", signal_out, -126);
    data_in_valid = 1'b0;
    tick();
    do_reset();

    // Full training burst from reset
    tick();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    chk("t4_training", training, 1);
    chk("t4_no_emit", signal_out_valid, 0);
    run_burst(1'b1, 1'b0, 0, p);
    chk("t4_burst_len", p, TL);
    chk("t4_training_end", training, 0);
    tick();
    chk("t4_ready_back", data_in_ready, 1);

    // Start with data valid, then ignored stimulus mid-burst
    train_start = 1'b1; data_in_valid = 1'b1; data_in = 2'b10;
    #1;
    chk("t5_ready_blocked", data_in_ready, 0);
    tick();
    train_start = 1'b0;
    chk("t5_training", training, 1);
    chk("t5_no_accept", signal_out_valid, 0);
    run_burst(1'b0, 1'b1, 0, p);
    chk("t5_burst_len", p, TL);
    tick();

    // Abort at symbol 50, restart from seed
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    run_burst(1'b0, 1'b0, 50, p);
    tick();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
    chk("t6_training", training, 1);
    run_burst(1'b1, 1'b0, 0, p);
    chk("t6_burst_len", p, TL);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
